round_key_buffer: RTL and testbench
===================================

Name: round_key_buffer

Overview:
Sits directly downstream of key_expansion and drives its rnd_key_gen.
- After each new seed key, runs one 40-cycle key-schedule burst.
- Packs the streamed 32-bit words w4..w43 into ten 128-bit round keys and stores them.
- Serves the stored keys to the cipher round datapath by round index, so the schedule is computed once per seed, not once per block.

Parameters:
NUM_ROUNDS, 10, number of stored round keys (round 0 = seed key, supplied elsewhere via seed_key)
WORD_WIDTH, 32, width of one key-schedule word
KEY_WIDTH, 128, round key width (4 words)
IDX_WIDTH, 4, round index width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
key_available  input  1  one-cycle pulse from key_expansion: new seed key loaded
rnd_word_key_val  input  WORD_WIDTH  expanded key word from key_expansion
rnd_word_key_val_vld  input  1  rnd_word_key_val valid this cycle
rnd_key_gen  output  1  registered; requests word generation from key_expansion
rnd_key_req  input  1  read request from round datapath
rnd_key_idx  input  IDX_WIDTH  requested round, legal 1..NUM_ROUNDS
rnd_key  output  KEY_WIDTH  round key, word 0 in [127:96], word 3 in [31:0]
rnd_key_vld  output  1  rnd_key valid (one-cycle pulse)
rnd_key_err  output  1  one-cycle pulse: illegal index or request while not READY
keys_ready  output  1  all NUM_ROUNDS keys stored and valid
busy  output  1  high in LOAD or GEN

Behaviour:
- Reset:
  - State IDLE, word counter 0.
  - All outputs 0.
  - Key store cleared to 0.
- FSM states:
  - IDLE: waiting for a seed key.
  - LOAD: exactly 1 cycle; rnd_key_gen=0 so key_expansion reloads its seed words.
  - GEN: rnd_key_gen=1; capture words.
  - READY: keys_ready=1; serve reads.
- Transitions:
  - key_available=1 in any state -> LOAD next cycle. It restarts the burst, clears keys_ready, drops rnd_key_gen and resets the word counter.
  - LOAD -> GEN unconditionally.
  - GEN -> READY on the cycle the 40th word (counter=39) is captured.
  - READY holds until the next key_available.
- GEN capture:
  - 6-bit word counter wc, 0..39.
  - On each rnd_word_key_val_vld: word is written to round (wc[5:2]+1), word slot wc[1:0], then wc increments.
  - A GEN cycle without vld neither writes nor advances. The protocol requires vld every GEN cycle; this is not flagged.
  - vld outside GEN is ignored.
- Timing: key_available at cycle T ->
  - LOAD at T+1.
  - rnd_key_gen high T+2..T+41 (40 cycles).
  - keys_ready high from T+42, rnd_key_gen low at T+42.
- Reads, in READY only:
  - rnd_key_req with idx 1..10 at cycle T gives rnd_key = stored key and rnd_key_vld=1 at T+1.
  - Back-to-back requests are supported, one per cycle.
  - idx 0 or >10 gives rnd_key_err=1 at T+1, rnd_key_vld=0, rnd_key=0.
  - A request in IDLE/LOAD/GEN gives rnd_key_err=1 at T+1, vld=0.
  - rnd_key is 0 whenever rnd_key_vld=0.
- Simultaneous key_available and rnd_key_req in READY:
  - key_available wins.
  - Request dropped with rnd_key_err=1 next cycle.
  - State goes to LOAD.
- Reset mid-GEN: immediate return to IDLE, keys_ready=0, store cleared. A partial burst is never marked ready.
- Key store is written only in GEN. Old keys remain readable internally until overwritten, but are never served (keys_ready=0).

Decomposition:
- Add to the shared define file chip_defines.v:
  - RKB state encodings: IDLE=2'b00, LOAD=2'b01, GEN=2'b10, READY=2'b11.
  - NUM_ROUNDS (10), KEY_WORDS (40), ROUND_IDX_WIDTH.
  - Reuse the existing word-slice defines for the word slots.
- One sub-module, round_key_store: 10x128 register file.
  - Write port: round index, word slot, word, write enable.
  - Registered read port.
  - Asynchronous clear.
- FSM, counter and handshake logic live in round_key_buffer.

Test Plan:
- FIPS-197 burst. After reset, pulse key_available, then stream words of key 2b7e151628aed2a6abf7158809cf4f3c from a key_expansion model. Required response:
  - rnd_key_gen high exactly 40 cycles starting 2 cycles after the pulse.
  - keys_ready at +42.
  - Read idx 1 -> a0fafe1788542cb123a339392a6c7605.
  - Read idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Back-to-back reads idx 10,9,...,1 on consecutive cycles -> 10 consecutive rnd_key_vld pulses with the correct keys, 1-cycle latency.
- Illegal accesses, each -> rnd_key_err pulse, vld=0, rnd_key=0:
  - idx 0 in READY.
  - idx 11 in READY.
  - idx 5 during GEN.
- Restart at cycle 20 of GEN with key 000102030405060708090a0b0c0d0e0f. Required response:
  - rnd_key_gen drops for exactly 1 cycle, then 40 new cycles.
  - Final idx 10 reads 13111d7fe3944a17f307a78b4d2b30c5.
- key_available and rnd_key_req in the same READY cycle -> err pulse, no vld, busy=1 next cycle.
- Async reset mid-GEN, then a 3-cycle vld gap in a new burst:
  - All outputs 0 immediately on reset.
  - The gap stalls wc.
  - keys_ready is delayed by exactly 3 cycles.

Source files
------------

// File: rtl/round_key_buffer_pkg.sv
// Shared constants, FSM encoding and helpers for the round key buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package round_key_buffer_pkg;

  localparam int NUM_ROUNDS    = 10;  // stored round keys (rounds 1..10)
  localparam int WORD_WIDTH    = 32;  // one key-schedule word
  localparam int KEY_WIDTH     = 128; // one round key
  localparam int IDX_WIDTH     = 4;   // round index width
  localparam int WORDS_PER_KEY = 4;
  localparam int SLOT_WIDTH    = 2;   // word slot within a round key
  localparam int KEY_WORDS     = NUM_ROUNDS * WORDS_PER_KEY; // w4..w43
  localparam int WC_WIDTH      = 6;   // word counter, 0..KEY_WORDS-1

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_GEN   = 2'b10,
    ST_READY = 2'b11
  } rkb_state_e;

  // Legal read indices are 1..NUM_ROUNDS; round 0 is the seed key held elsewhere.
  function automatic logic idx_legal(input logic [IDX_WIDTH-1:0] idx);
    return (idx != '0) && (idx <= IDX_WIDTH'(NUM_ROUNDS));
  endfunction

endpackage

// File: rtl/round_key_buffer_store.sv
// Round key register file: NUM_ROUNDS x KEY_WIDTH, written one word at a time.
// Latency: write lands next edge; read data registered, valid 1 cycle after rd_en_i.
// Backpressure: none; one write and one read accepted every cycle.
//
// Ports: clk_i/rst_i (async active-high clear), wr_en_i/wr_round_i/wr_slot_i/
// wr_word_i (word write, 0-based round), rd_en_i/rd_round_i (0-based round),
// rd_key_o (registered read data, forced to 0 when no read was issued).
module round_key_store
  import round_key_buffer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [IDX_WIDTH-1:0]  wr_round_i,
  input  logic [SLOT_WIDTH-1:0] wr_slot_i,
  input  logic [WORD_WIDTH-1:0] wr_word_i,
  input  logic                  rd_en_i,
  input  logic [IDX_WIDTH-1:0]  rd_round_i,
  output logic [KEY_WIDTH-1:0]  rd_key_o
);

  // Stored per word so a write touches exactly one 32-bit slot.
  logic [WORD_WIDTH-1:0] mem_q [NUM_ROUNDS][WORDS_PER_KEY];
  logic [KEY_WIDTH-1:0]  rd_key_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_ROUNDS; r++) begin
        for (int s = 0; s < WORDS_PER_KEY; s++) begin
          mem_q[r][s] <= '0;
        end
      end
      rd_key_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_round_i][wr_slot_i] <= wr_word_i;
      end
      // Slot 0 is the most significant word of the round key.
      if (rd_en_i) begin
        rd_key_q <= {mem_q[rd_round_i][0], mem_q[rd_round_i][1],
                     mem_q[rd_round_i][2], mem_q[rd_round_i][3]};
      end else begin
        rd_key_q <= '0;
      end
    end
  end

  assign rd_key_o = rd_key_q;

endmodule

// File: rtl/round_key_buffer.sv
// Runs one 40-word key-schedule burst per seed, packs w4..w43 into 10 round keys, serves them by index.
// Latency: keys_ready 42 cycles after key_available; read data 1 cycle after rnd_key_req.
// Backpressure: none; words must arrive every GEN cycle (gaps stall), one read per cycle.
//
// Ports: clk, reset (async active-high); key_available (seed pulse);
// rnd_word_key_val/_vld (word stream in); rnd_key_gen (registered word request);
// rnd_key_req/rnd_key_idx (read request); rnd_key/rnd_key_vld/rnd_key_err (read
// response); keys_ready (all keys valid); busy (LOAD or GEN).
module round_key_buffer
  import round_key_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_available,
  input  logic [WORD_WIDTH-1:0] rnd_word_key_val,
  input  logic                  rnd_word_key_val_vld,
  output logic                  rnd_key_gen,
  input  logic                  rnd_key_req,
  input  logic [IDX_WIDTH-1:0]  rnd_key_idx,
  output logic [KEY_WIDTH-1:0]  rnd_key,
  output logic                  rnd_key_vld,
  output logic                  rnd_key_err,
  output logic                  keys_ready,
  output logic                  busy
);

  rkb_state_e          state_q, state_d;
  logic [WC_WIDTH-1:0] wc_q, wc_d;
  logic                gen_q;
  logic                vld_q;
  logic                err_q, err_d;
  logic                wr_en;
  logic                rd_en;
  logic [IDX_WIDTH-1:0] rd_round;

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    wr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_LOAD:  state_d = ST_GEN;
      ST_GEN: begin
        // A GEN cycle without a valid word simply stalls the counter.
        if (rnd_word_key_val_vld) begin
          wr_en = 1'b1;
          if (wc_q == WC_WIDTH'(KEY_WORDS - 1)) begin
            state_d = ST_READY;
            wc_d    = '0;
          end else begin
            wc_d = wc_q + WC_WIDTH'(1);
          end
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_IDLE;
    endcase

    // A new seed restarts the burst from any state, including mid-burst.
    if (key_available) begin
      state_d = ST_LOAD;
      wc_d    = '0;
    end

    // key_available in the same cycle as a read wins; the read is refused.
    rd_en = rnd_key_req && (state_q == ST_READY) && !key_available &&
            idx_legal(rnd_key_idx);
    err_d = rnd_key_req && !rd_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wc_q    <= '0;
      gen_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      // Registered request; drops for the LOAD cycle so key_expansion reseeds.
      gen_q   <= (state_d == ST_GEN);
      vld_q   <= rd_en;
      err_q   <= err_d;
    end
  end

  // External round r (1..10) lives in store row r-1; wc[5:2] is already that row.
  assign rd_round = rnd_key_idx - IDX_WIDTH'(1);

  round_key_store u_store (
    .clk_i      (clk),
    .rst_i      (reset),
    .wr_en_i    (wr_en),
    .wr_round_i (wc_q[WC_WIDTH-1:SLOT_WIDTH]),
    .wr_slot_i  (wc_q[SLOT_WIDTH-1:0]),
    .wr_word_i  (rnd_word_key_val),
    .rd_en_i    (rd_en),
    .rd_round_i (rd_round),
    .rd_key_o   (rnd_key)
  );

  assign rnd_key_gen = gen_q;
  assign rnd_key_vld = vld_q;
  assign rnd_key_err = err_q;
  assign keys_ready  = (state_q == ST_READY);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_GEN);

endmodule

// File: tb/tb_round_key_buffer.sv
// Self-checking bench for round_key_buffer with an AES-128 key_expansion source
// and a behavioural model of the key buffer.
module tb_round_key_buffer;

  logic         clk;
  logic         reset;
  logic         key_available;
  logic [31:0]  rnd_word_key_val;
  logic         rnd_word_key_val_vld;
  logic         rnd_key_gen;
  logic         rnd_key_req;
  logic [3:0]   rnd_key_idx;
  logic [127:0] rnd_key;
  logic         rnd_key_vld;
  logic         rnd_key_err;
  logic         keys_ready;
  logic         busy;

  round_key_buffer dut (
    .clk                  (clk),
    .reset                (reset),
    .key_available        (key_available),
    .rnd_word_key_val     (rnd_word_key_val),
    .rnd_word_key_val_vld (rnd_word_key_val_vld),
    .rnd_key_gen          (rnd_key_gen),
    .rnd_key_req          (rnd_key_req),
    .rnd_key_idx          (rnd_key_idx),
    .rnd_key              (rnd_key),
    .rnd_key_vld          (rnd_key_vld),
    .rnd_key_err          (rnd_key_err),
    .keys_ready           (keys_ready),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- AES-128 key expansion (source model) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) r = gmul(r, x); // x^254 = inverse, 0 -> 0
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  logic [31:0] ke_w [40];   // w4..w43 of the current seed

  task automatic load_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 40; i++) ke_w[i] = w[i+4];
  endtask

  // Word source: answers rnd_key_gen with one word per cycle, restarting on the
  // gen-low reload cycle; gap_req asks for a 3-cycle hole in the stream.
  int gap_req  = 0;
  int gap_seen = 0;
  int gap_left = 0;
  int ke_n     = 0;

  always @(negedge clk) begin
    if (gap_req != gap_seen) begin
      gap_seen = gap_req;
      gap_left = 3;
    end
    if (reset || !rnd_key_gen) begin
      ke_n = 0;
      rnd_word_key_val_vld = 1'b0;
      rnd_word_key_val     = 32'h0;
    end else if (gap_left > 0) begin
      gap_left--;
      rnd_word_key_val_vld = 1'b0;
    end else begin
      rnd_word_key_val_vld = 1'b1;
      rnd_word_key_val     = ke_w[ke_n];
      if (ke_n < 39) ke_n++;
    end
  end

  // ---------------- behavioural model of the buffer ----------------
  // m_active: burst running; m_fresh: the reload cycle right after a seed;
  // m_got: words captured so far; m_store: captured words in stream order.
  bit          m_active, m_fresh, m_ready;
  int          m_got;
  logic [31:0] m_store [40];
  logic        e_gen, e_busy, e_ready, e_vld, e_err;
  logic [127:0] e_key;
  bit          cur_gen;
  int          ri;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 0; m_fresh <= 0; m_ready <= 0; m_got <= 0;
      for (int i = 0; i < 40; i++) m_store[i] <= 32'h0;
      e_gen <= 0; e_busy <= 0; e_ready <= 0; e_vld <= 0; e_err <= 0; e_key <= '0;
    end else begin
      cur_gen = m_active && !m_fresh;
      if (cur_gen && rnd_word_key_val_vld) m_store[m_got] <= rnd_word_key_val;
      e_vld <= 0; e_err <= 0; e_key <= '0;
      if (rnd_key_req) begin
        ri = int'(rnd_key_idx);
        if (m_ready && !key_available && ri >= 1 && ri <= 10) begin
          e_vld <= 1;
          e_key <= {m_store[4*(ri-1)], m_store[4*(ri-1)+1], m_store[4*(ri-1)+2], m_store[4*(ri-1)+3]};
        end else begin
          e_err <= 1;
        end
      end
      if (key_available) begin
        m_active <= 1; m_fresh <= 1; m_got <= 0; m_ready <= 0;
        e_gen <= 0; e_busy <= 1; e_ready <= 0;
      end else if (m_fresh) begin
        m_fresh <= 0; e_gen <= 1; e_busy <= 1;
      end else if (cur_gen && rnd_word_key_val_vld) begin
        m_got <= m_got + 1;
        if (m_got == 39) begin
          m_active <= 0; m_ready <= 1;
          e_gen <= 0; e_busy <= 0; e_ready <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("gen",   {127'h0, rnd_key_gen}, {127'h0, e_gen});
      check("busy",  {127'h0, busy},        {127'h0, e_busy});
      check("ready", {127'h0, keys_ready},  {127'h0, e_ready});
      check("vld",   {127'h0, rnd_key_vld}, {127'h0, e_vld});
      check("err",   {127'h0, rnd_key_err}, {127'h0, e_err});
      check("key",   rnd_key,               e_key);
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  // Pulses key_available and watches the burst. lo/hi count gen-low/high
  // cycles and rdy is the cycle keys_ready appears, all relative to the last pulse.
  task automatic burst(input logic [127:0] key, input int restart_at, input logic [127:0] key2,
                       input int gap_after, input int gen_req_at,
                       output int lo, output int hi, output int rdy);
    int  base = 0;
    bit  restarted = 0, gapped = 0, reqd = 0, pend = 0;
    lo = 0; hi = 0; rdy = -1;
    load_key(key);
    @(negedge clk);
    key_available = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      key_available = 1'b0;
      if (pend) begin
        check("gen_req_err", {127'h0, rnd_key_err}, 128'h1);
        check("gen_req_vld", {127'h0, rnd_key_vld}, 128'h0);
        check("gen_req_key", rnd_key, 128'h0);
        rnd_key_req = 1'b0;
        pend = 0;
      end
      if (keys_ready) begin
        rdy = i - base;
        break;
      end
      if (rnd_key_gen) hi++; else lo++;
      if (restart_at > 0 && hi == restart_at && !restarted) begin
        restarted = 1;
        load_key(key2);
        key_available = 1'b1;
        base = i; lo = 0; hi = 0;
      end else if (gap_after > 0 && hi == gap_after && !gapped) begin
        gapped = 1;
        gap_req++;
      end
      if (gen_req_at > 0 && hi == gen_req_at && !reqd) begin
        reqd = 1; pend = 1;
        rnd_key_req = 1'b1;
        rnd_key_idx = 4'd5;
      end
    end
    if (rdy < 0) check("burst_timeout", 128'h0, 128'h1);
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] k,
                          output logic v, output logic e);
    @(negedge clk);
    rnd_key_req = 1'b1;
    rnd_key_idx = idx;
    @(negedge clk);
    rnd_key_req = 1'b0;
    k = rnd_key; v = rnd_key_vld; e = rnd_key_err;
  endtask

  initial begin
    int lo, hi, rdy, pulses;
    logic [127:0] k;
    logic v, e;
    bit got;

    reset = 1'b1; key_available = 1'b0; rnd_key_req = 1'b0; rnd_key_idx = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_gen",   {127'h0, rnd_key_gen}, 128'h0);
    check("rst_ready", {127'h0, keys_ready},  128'h0);
    check("rst_busy",  {127'h0, busy},        128'h0);
    check("rst_vld",   {127'h0, rnd_key_vld}, 128'h0);
    check("rst_key",   rnd_key,               128'h0);
    reset = 1'b0;
    chk_en = 1;

    // Request while IDLE is refused.
    read_key(4'd3, k, v, e);
    check("idle_err", {127'h0, e}, 128'h1);

    // FIPS-197 burst with an idx-5 request during GEN.
    burst(FIPS_KEY, 0, '0, 0, 5, lo, hi, rdy);
    check("fips_lo",  lo,  1);
    check("fips_hi",  hi,  40);
    check("fips_rdy", rdy, 42);
    read_key(4'd1, k, v, e);
    check("fips_r1", k, FIPS_R1);
    check("fips_r1_vld", {127'h0, v}, 128'h1);
    read_key(4'd10, k, v, e);
    check("fips_r10", k, FIPS_R10);

    // Illegal indices in READY.
    read_key(4'd0, k, v, e);
    check("idx0_err", {127'h0, e}, 128'h1);
    check("idx0_key", k, 128'h0);
    read_key(4'd11, k, v, e);
    check("idx11_err", {127'h0, e}, 128'h1);
    check("idx11_vld", {127'h0, v}, 128'h0);

    // Back-to-back reads 10..1.
    pulses = 0;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j > 0 && rnd_key_vld) pulses++;
      if (j == 1)  check("b2b_first", rnd_key, FIPS_R10);
      if (j == 10) check("b2b_last",  rnd_key, FIPS_R1);
      if (j < 10) begin
        rnd_key_req = 1'b1;
        rnd_key_idx = 4'(10 - j);
      end else begin
        rnd_key_req = 1'b0;
      end
    end
    check("b2b_pulses", pulses, 10);

    // Restart at GEN cycle 20 with the sequential key.
    burst(FIPS_KEY, 20, SEQ_KEY, 0, 0, lo, hi, rdy);
    check("rst20_lo",  lo,  1);
    check("rst20_hi",  hi,  40);
    check("rst20_rdy", rdy, 42);
    read_key(4'd10, k, v, e);
    check("seq_r10", k, SEQ_R10);

    // key_available and a read in the same READY cycle.
    load_key(FIPS_KEY);
    @(negedge clk);
    key_available = 1'b1;
    rnd_key_req = 1'b1;
    rnd_key_idx = 4'd3;
    @(negedge clk);
    key_available = 1'b0;
    rnd_key_req = 1'b0;
    check("coll_err",  {127'h0, rnd_key_err}, 128'h1);
    check("coll_vld",  {127'h0, rnd_key_vld}, 128'h0);
    check("coll_busy", {127'h0, busy},        128'h1);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = keys_ready;
    end
    check("coll_done", {127'h0, got}, 128'h1);

    // Async reset in the middle of a burst.
    @(negedge clk);
    key_available = 1'b1;
    @(negedge clk);
    key_available = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_gen",   {127'h0, rnd_key_gen}, 128'h0);
    check("arst_ready", {127'h0, keys_ready},  128'h0);
    check("arst_busy",  {127'h0, busy},        128'h0);
    check("arst_vld",   {127'h0, rnd_key_vld}, 128'h0);
    check("arst_err",   {127'h0, rnd_key_err}, 128'h0);
    check("arst_key",   rnd_key,               128'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // New burst with a 3-cycle hole in the word stream.
    burst(FIPS_KEY, 0, '0, 10, 0, lo, hi, rdy);
    check("gap_hi",  hi,  43);
    check("gap_rdy", rdy, 45);
    read_key(4'd10, k, v, e);
    check("gap_r10", k, FIPS_R10);

    // Random seeds and random read traffic, checked by the model.
    for (int n = 0; n < 3; n++) begin
      burst({$urandom, $urandom, $urandom, $urandom}, 0, '0, 0, 0, lo, hi, rdy);
      check("rand_rdy", rdy, 42);
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        rnd_key_req = 1'($urandom_range(0, 1));
        rnd_key_idx = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      rnd_key_req = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
